i2c_fifo_sequencer: RTL

I2C_FIFO_SEQUENCER -- requirements
Module: i2c_fifo_sequencer

---
 rtl/i2c_fifo_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/i2c_fifo_sequencer.sv
// i2c_fifo_sequencer: drives START / address / payload WRITEs / STOP commands into an I2C
// byte engine, popping one TX FIFO byte per payload WRITE.
module i2c_fifo_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [6:0]            slave_addr,
    input  logic [CNT_WIDTH-1:0]  byte_count,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_type,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_ready,
    input  logic                  eng_done,
    input  logic                  eng_nack,
    output logic                  busy,
    output logic                  done,
    output logic                  nack_err
);
    typedef enum logic [2:0] {IDLE, START, ADDR, FETCH, LOAD, WRITE, STOP, FINISH} state_t;
    localparam logic [1:0] CMD_START = 2'b00, CMD_WRITE = 2'b01, CMD_STOP = 2'b10;
    state_t state;
    logic [6:0] addr_q;
    logic [CNT_WIDTH-1:0] remain;
    logic waiting;
    logic cmd_fin;
    // eng_done only counts once the current command has been handed over
    assign cmd_fin = waiting && eng_done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack_err   <= 1'b0;
            fifo_rd_en <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_type   <= CMD_START;
            cmd_data   <= '0;
            remain     <= '0;
            addr_q     <= '0;
            waiting    <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                waiting   <= 1'b1;
            end
            case (state)
                IDLE: if (go) begin
                    addr_q    <= slave_addr;
                    remain    <= byte_count;
                    nack_err  <= 1'b0;
                    busy      <= 1'b1;
                    cmd_valid <= 1'b1;
                    cmd_type  <= CMD_START;
                    cmd_data  <= '0;
                    state     <= START;
                end
                START: if (cmd_fin) begin
                    waiting   <= 1'b0;
                    cmd_valid <= 1'b1;
                    cmd_type  <= CMD_WRITE;
                    cmd_data  <= DATA_WIDTH'({addr_q, 1'b0});
                    state     <= ADDR;
                end
                ADDR, WRITE: if (cmd_fin) begin
                    waiting  <= 1'b0;
                    cmd_data <= '0;
                    if (eng_nack || remain == '0) begin
                        nack_err  <= eng_nack;
                        cmd_valid <= 1'b1;
                        cmd_type  <= CMD_STOP;
                        state     <= STOP;
                    end else begin
                        state <= FETCH;
                    end
                end
                FETCH: if (!fifo_empty) begin
                    fifo_rd_en <= 1'b1;
                    state      <= LOAD;
                end
                // first LOAD cycle ends the pop; the registered read data is captured on the next
                LOAD: if (fifo_rd_en) begin
                    fifo_rd_en <= 1'b0;
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_type  <= CMD_WRITE;
                    cmd_data  <= fifo_data;
                    remain    <= (remain != '0) ? remain - 1'b1 : remain;
                    state     <= WRITE;
                end
                STOP: if (cmd_fin) begin
                    waiting <= 1'b0;
                    done    <= 1'b1;
                    state   <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
